// File: rtl/mem_noc_arb_nto1_if.sv
// Memory request/response channel bundle, one lane per attached agent.
// The master modport drives requests; the slave modport answers them.
interface mem_noc_arb_nto1_if #(
    parameter int unsigned N      = 1,
    parameter int unsigned REQ_W  = 64,
    parameter int unsigned RESP_W = 32
);
    logic [N-1:0]             req_valid;
    logic [N-1:0]             req_ready;
    logic [N-1:0][REQ_W-1:0]  req;
    logic [N-1:0]             resp_valid;
    logic [N-1:0]             resp_ready;
    logic [N-1:0][RESP_W-1:0] resp;

    modport master (
        output req_valid, req, resp_ready,
        input  req_ready, resp_valid, resp
    );

    modport slave (
        input  req_valid, req, resp_ready,
        output req_ready, resp_valid, resp
    );
endinterface

// File: rtl/mem_noc_arb_nto1.sv
// N-master to 1-slave memory arbiter with an in-order outstanding-request FIFO that
// steers slave responses back to the issuing master.
module mem_noc_arb_nto1 #(
    parameter int unsigned N         = 3,
    parameter int unsigned OST_DEPTH = 4,
    parameter int unsigned ARB_MODE  = 0,
    parameter int unsigned REQ_W     = 64,
    parameter int unsigned RESP_W    = 32,
    localparam int unsigned IW       = $clog2(N),
    localparam int unsigned CW       = $clog2(OST_DEPTH + 1)
) (
    input  logic                   i_clk,
    input  logic                   i_rstn,
    mem_noc_arb_nto1_if.slave      mn,
    mem_noc_arb_nto1_if.master     sn,
    output logic [CW-1:0]          o_ost_cnt,
    output logic                   o_resp_err
);
    localparam int unsigned PW = $clog2(OST_DEPTH);
    localparam logic [PW:0] PtrOne = (PW + 1)'(1);

    logic [IW-1:0] r_rr_ptr;
    logic          r_lock;
    logic [IW-1:0] r_lk_idx;
    logic [IW-1:0] r_fifo [OST_DEPTH];
    logic [PW:0]   r_wr_ptr;
    logic [PW:0]   r_rd_ptr;
    logic          r_resp_err;

    logic [IW-1:0] w_grant;
    logic [IW-1:0] w_cand;
    logic          w_found;
    int unsigned   w_idx;
    logic [IW-1:0] w_head;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_stall;
    logic          w_orphan;

    assign w_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) && (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_head  = r_fifo[r_rd_ptr[PW-1:0]];

    // Scan candidates in priority order: from rr_ptr (round-robin) or from 0 (fixed).
    always_comb begin
        w_grant = '0;
        w_found = 1'b0;
        w_idx   = 0;
        w_cand  = '0;
        if (r_lock) begin
            w_grant = r_lk_idx;
        end else begin
            for (int unsigned k = 0; k < N; k++) begin
                w_idx = (ARB_MODE == 0) ? 32'(r_rr_ptr) + k : k;
                if (w_idx >= N) w_idx = w_idx - N;
                w_cand = IW'(w_idx);
                if (!w_found && mn.req_valid[w_cand]) begin
                    w_grant = w_cand;
                    w_found = 1'b1;
                end
            end
        end
    end

    assign sn.req_valid[0] = (|mn.req_valid) & ~w_full;
    assign sn.req[0]       = mn.req[w_grant];
    assign w_push          = sn.req_valid[0] & sn.req_ready[0];
    assign w_stall         = sn.req_valid[0] & ~sn.req_ready[0];

    always_comb begin
        mn.req_ready          = '0;
        mn.req_ready[w_grant] = sn.req_ready[0] & ~w_full;
    end

    // An empty FIFO sinks any response so a misbehaving slave cannot wedge the bus.
    always_comb begin
        mn.resp_valid         = '0;
        mn.resp_valid[w_head] = sn.resp_valid[0] & ~w_empty;
        for (int unsigned i = 0; i < N; i++) begin
            mn.resp[i] = sn.resp[0];
        end
        sn.resp_ready[0] = w_empty ? sn.resp_valid[0] : mn.resp_ready[w_head];
    end

    assign w_pop    = sn.resp_valid[0] & sn.resp_ready[0] & ~w_empty;
    assign w_orphan = sn.resp_valid[0] & w_empty;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_rr_ptr   <= '0;
            r_lock     <= 1'b0;
            r_lk_idx   <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_resp_err <= 1'b0;
        end else begin
            r_lock <= w_stall;
            if (w_stall) r_lk_idx <= w_grant;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PtrOne;
                if (ARB_MODE == 0) begin
                    r_rr_ptr <= (w_grant == IW'(N - 1)) ? '0 : w_grant + IW'(1);
                end
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + PtrOne;
            if (w_orphan) r_resp_err <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_fifo[r_wr_ptr[PW-1:0]] <= w_grant;
    end

    assign o_ost_cnt  = CW'(r_wr_ptr - r_rd_ptr);
    assign o_resp_err = r_resp_err;
endmodule

// File: tb/tb_mem_noc_arb_nto1.sv
// Randomised scoreboard bench: one round-robin and one fixed-priority arbiter, each
// checked against a queue-based reference model, followed by a directed orphan/reset case.
module tb_mem_noc_arb_nto1;
    localparam int N  = 3;
    localparam int D  = 4;
    localparam int W  = 16;
    localparam int CW = 3;

    typedef struct {
        int           m;
        logic [W-1:0] d;
    } exp_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   errs = 0;
    int   chks = 0;
    bit   quiet  = 1'b0;
    bit   inject = 1'b0;

    always #5 clk = ~clk;

    function automatic void chk(int inst, string nm, int unsigned act, int unsigned exp);
        chks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, inst, act, exp);
        end
    endfunction

    function automatic logic [W-1:0] rsp_of(logic [W-1:0] p);
        return {p[7:0], p[15:8]} ^ 16'h3c5a;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_h
        mem_noc_arb_nto1_if #(.N(N), .REQ_W(W), .RESP_W(W)) mn ();
        mem_noc_arb_nto1_if #(.N(1), .REQ_W(W), .RESP_W(W)) sn ();
        logic [CW-1:0] ost;
        logic          rerr;

        mem_noc_arb_nto1 #(
            .N(N), .OST_DEPTH(D), .ARB_MODE(g), .REQ_W(W), .RESP_W(W)
        ) dut (
            .i_clk(clk), .i_rstn(rstn), .mn(mn), .sn(sn), .o_ost_cnt(ost), .o_resp_err(rerr)
        );

        logic [W-1:0] pay [N];
        bit           acc [N];
        logic [W-1:0] sq [$];
        exp_t         eq [$];
        int           rr = 0;
        bit           lk = 1'b0;
        int           lki = 0;
        bit           err_m = 1'b0;
        int req_pct = 100, srdy_pct = 100, rsp_pct = 0, mrdy_pct = 100, cyc = 0;

        // Stimulus: masters hold each request until accepted; slave answers in order.
        initial begin
            mn.req_valid  = '0;
            mn.req        = '0;
            mn.resp_ready = '0;
            sn.req_ready  = '0;
            sn.resp_valid = '0;
            sn.resp       = '0;
            for (int m = 0; m < N; m++) pay[m] = '0;
            forever begin
                @(posedge clk);
                #1;
                cyc++;
                if (cyc == 16) rsp_pct = 50;
                if (cyc % 64 == 0) begin
                    req_pct  = $urandom_range(20, 100);
                    srdy_pct = $urandom_range(20, 100);
                    rsp_pct  = $urandom_range(5, 100);
                    mrdy_pct = $urandom_range(30, 100);
                end
                for (int m = 0; m < N; m++) begin
                    if (!rstn) begin
                        mn.req_valid[m] = 1'b0;
                    end else begin
                        if (mn.req_valid[m] && acc[m]) mn.req_valid[m] = 1'b0;
                        if (!mn.req_valid[m] && !quiet && $urandom_range(0, 99) < req_pct) begin
                            pay[m] = {m[3:0], 12'($urandom)};
                            mn.req[m] = pay[m];
                            mn.req_valid[m] = 1'b1;
                        end
                    end
                    mn.resp_ready[m] = quiet || ($urandom_range(0, 99) < mrdy_pct);
                end
                sn.req_ready[0] = quiet || ($urandom_range(0, 99) < srdy_pct);
                if (inject) begin
                    sn.resp_valid[0] = 1'b1;
                    sn.resp[0]       = 16'hdead;
                end else if (rstn && sq.size() > 0 &&
                             (quiet || $urandom_range(0, 99) < rsp_pct)) begin
                    sn.resp_valid[0] = 1'b1;
                    sn.resp[0]       = rsp_of(sq[0]);
                end else begin
                    sn.resp_valid[0] = 1'b0;
                    sn.resp[0]       = W'($urandom);
                end
            end
        end

        // Monitor and reference model, evaluated mid-cycle while inputs are stable.
        always @(negedge clk) begin
            int           eg;
            int           size0;
            bit           ev;
            bit           any;
            logic [N-1:0] erdy;
            exp_t         h;
            exp_t         e;
            if (!rstn) begin
                sq.delete();
                eq.delete();
                rr = 0;
                lk = 1'b0;
                lki = 0;
                err_m = 1'b0;
                for (int m = 0; m < N; m++) acc[m] = 1'b0;
            end else begin
                size0 = eq.size();
                any   = |mn.req_valid;
                eg    = 0;
                if (lk) begin
                    eg = lki;
                end else if (any) begin
                    for (int k = N - 1; k >= 0; k--) begin
                        if (g == 1 && mn.req_valid[k]) eg = k;
                        if (g == 0 && mn.req_valid[(rr + k) % N]) eg = (rr + k) % N;
                    end
                end
                ev = any && (size0 < D);
                chk(g, "sn_req_valid", sn.req_valid[0], ev);
                if (ev) chk(g, "sn_req", sn.req[0], pay[eg]);
                if (any) begin
                    erdy = '0;
                    if (sn.req_ready[0] && size0 < D) erdy[eg] = 1'b1;
                    chk(g, "mn_req_ready", mn.req_ready, erdy);
                end
                chk(g, "ost_cnt", ost, size0);
                chk(g, "resp_err", rerr, err_m);

                for (int m = 0; m < N; m++) acc[m] = mn.req_valid[m] & mn.req_ready[m];

                if (sn.resp_valid[0]) begin
                    if (size0 == 0) begin
                        chk(g, "orphan_sn_resp_ready", sn.resp_ready[0], 1);
                        chk(g, "orphan_mn_resp_valid", mn.resp_valid, 0);
                        err_m = 1'b1;
                    end else begin
                        h = eq[0];
                        chk(g, "mn_resp_valid", mn.resp_valid, 1 << h.m);
                        chk(g, "mn_resp", mn.resp[h.m], h.d);
                        chk(g, "sn_resp_ready", sn.resp_ready[0], mn.resp_ready[h.m]);
                        if (mn.resp_ready[h.m]) void'(eq.pop_front());
                    end
                end else begin
                    chk(g, "mn_resp_idle", mn.resp_valid, 0);
                end
                if (sn.resp_valid[0] && sn.resp_ready[0] && sq.size() > 0) void'(sq.pop_front());

                if (sn.req_valid[0] && sn.req_ready[0]) sq.push_back(sn.req[0]);
                if (ev && sn.req_ready[0]) begin
                    e.m = eg;
                    e.d = rsp_of(pay[eg]);
                    eq.push_back(e);
                    if (g == 0) rr = (eg + 1) % N;
                end
                lk = ev && !sn.req_ready[0];
                if (lk) lki = eg;
            end
        end
    end

    initial begin
        bit busy;
        @(negedge clk);
        chk(0, "rst_ost", g_h[0].ost, 0);
        chk(1, "rst_ost", g_h[1].ost, 0);
        chk(0, "rst_err", g_h[0].rerr, 0);
        chk(1, "rst_err", g_h[1].rerr, 0);
        chk(0, "rst_sn_req_valid", g_h[0].sn.req_valid, 0);
        chk(1, "rst_sn_req_valid", g_h[1].sn.req_valid, 0);
        chk(0, "rst_mn_resp_valid", g_h[0].mn.resp_valid, 0);
        chk(1, "rst_mn_resp_valid", g_h[1].mn.resp_valid, 0);
        repeat (2) @(posedge clk);
        #2 rstn = 1'b1;

        repeat (2500) @(posedge clk);
        quiet = 1'b1;
        busy  = 1'b1;
        for (int c = 0; c < 200 && busy; c++) begin
            @(negedge clk);
            busy = (g_h[0].eq.size() != 0) || (g_h[1].eq.size() != 0) ||
                   (|g_h[0].mn.req_valid) || (|g_h[1].mn.req_valid);
        end
        chk(0, "drain_timeout", busy, 0);

        // Orphan response into empty FIFOs: sticky error until reset.
        @(negedge clk);
        inject = 1'b1;
        @(negedge clk);
        inject = 1'b0;
        @(negedge clk);
        chk(0, "orphan_err_set", g_h[0].rerr, 1);
        chk(1, "orphan_err_set", g_h[1].rerr, 1);
        repeat (3) @(negedge clk);
        chk(0, "orphan_err_held", g_h[0].rerr, 1);
        chk(1, "orphan_err_held", g_h[1].rerr, 1);
        @(posedge clk);
        #2 rstn = 1'b0;
        repeat (2) @(negedge clk);
        chk(0, "rst_clears_err", g_h[0].rerr, 0);
        chk(1, "rst_clears_err", g_h[1].rerr, 0);
        chk(0, "rst_clears_ost", g_h[0].ost, 0);
        chk(1, "rst_clears_ost", g_h[1].ost, 0);
        @(posedge clk);
        #2 rstn = 1'b1;
        quiet = 1'b0;
        repeat (400) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errs, chks);
        $finish;
    end
endmodule
